sdpram_arbiter: RTL
===================

Name: sdpram_arbiter

Overview:
- Single-clock scheduler in front of the gsm_switch simple-dual-port buffer RAM (1 write port A, 1 read port B, both internally input-registered, output-registered on B).
- Shares write port A between NREQ requesters using round-robin with burst lock.
- Sequences read port B for one reader and returns read data with a fixed-latency valid strobe.
- Resolves same-cycle read/write collisions to the same address.

Parameters:
- NREQ, 4, number of write requesters (2..8)
- DWIDTH, 18, RAM data width
- AWIDTH, 10, RAM address width

Ports:
- clk  in  1  system clock, also drives both RAM clocks
- rst_n  in  1  synchronous active-low reset
- wr_req  in  NREQ  per-requester write request
- wr_last  in  NREQ  marks the final word of the requester's burst
- wr_addr  in  NREQ*AWIDTH  packed write addresses, requester i at [i*AWIDTH +: AWIDTH]
- wr_data  in  NREQ*DWIDTH  packed write data, same packing
- wr_gnt  out  NREQ  one-hot grant; word accepted this cycle
- rd_req  in  1  read request
- rd_addr  in  AWIDTH  read address
- rd_ack  out  1  read accepted this cycle
- rd_valid  out  1  read data valid
- rd_data  out  DWIDTH  read data
- ram_en_a, ram_write_a  out  1 each  RAM port A enable and write
- ram_addr_a  out  AWIDTH  RAM port A address
- ram_wr_data_a  out  DWIDTH  RAM port A write data
- ram_en_b  out  1  RAM port B enable
- ram_addr_b  out  AWIDTH  RAM port B address
- ram_rd_data_b  in  DWIDTH  RAM port B data

Behaviour:
- Reset, while rst_n is low at an edge:
  - FSM goes to IDLE; rr_ptr = NREQ-1, so requester 0 has first priority; owner = 0.
  - rd_valid pipeline is cleared.
  - wr_gnt, rd_ack, ram_en_a, ram_write_a and ram_en_b are forced to 0.
  - The RAM array itself is not reset.
- Write grant is combinational in cycle t. ram_en_a = ram_write_a = |wr_gnt, and address/data are muxed from the granted requester. The RAM commits the word at the end of t+1.
- Requester handshake:
  - A requester holds wr_req, addr and data stable until granted.
  - Dropping wr_req before grant is legal; the request is simply withdrawn.
- FSM IDLE:
  - Grant the first asserted wr_req searching from rr_ptr+1 modulo NREQ.
  - If the granted requester has wr_last=1: stay in IDLE and set rr_ptr to that requester.
  - If wr_last=0: go to LOCKED and set owner to that requester.
- FSM LOCKED:
  - Only owner is eligible. Gaps where owner's wr_req is low are allowed; the lock is kept and no other requester is granted.
  - A grant with wr_last=1 sets rr_ptr = owner and returns to IDLE.
- Read path:
  - rd_ack = rd_req & ~collision; ram_en_b = rd_ack; ram_addr_b = rd_addr.
  - rd_valid is asserted exactly 2 cycles after rd_ack, via a 2-flop shift register. rd_data = ram_rd_data_b, passed through.
  - Back-to-back reads sustain 1 per cycle.
- Collision: collision = rd_req & (|wr_gnt) & (rd_addr == granted wr_addr).
  - The read is stalled (rd_ack=0) for that cycle.
  - A read acked in cycle t+1 returns the data written in cycle t.
  - The write is never stalled by a read.
- A read in cycle t always observes every write granted in cycle ≤ t-1.
- Ordering: reads return in request order; there is no reordering.
- Reset mid-burst: the lock is abandoned. In-flight read data returns but is not flagged by rd_valid.

Decomposition:
- Shared package gsm_sw_pkg:
  - FSM state encoding (ST_IDLE, ST_LOCKED).
  - RAM read latency constant RD_LAT = 2.
- Sub-module rr_arbiter: parameterised NREQ round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index.
  - Purely combinational; the parent owns all state.

Test Plan:
- Reset, then wr_req=4'b1111 with wr_last=4'b1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, exactly one per cycle; RAM holds all 8 words.
- req1 burst of 3 words (wr_last on the 3rd) with req2 asserted throughout -> wr_gnt = 0010 ×3, then 0100; a 1-cycle gap in req1 mid-burst does not grant req2.
- Write 0x2AAAA to addr 5, then a read of addr 5 one cycle later -> rd_ack high; rd_valid 2 cycles after, with rd_data = 0x2AAAA.
- Same cycle: write 0x15555 to addr 9 and read addr 9 (old value 0) -> rd_ack=0 that cycle, ack next cycle; rd_valid returns 0x15555.
- Continuous reads of addresses 0..15 -> rd_ack every cycle; rd_valid continuous, starting at ack+2, with data in address order.
- Assert rst_n=0 for 1 cycle during a LOCKED burst of req2, with req0 pending -> the first grant after reset goes to req0 and rd_valid is 0 during and after reset until a new ack.

Source files
------------

// File: rtl/gsm_sw_pkg.sv
// Shared definitions for the gsm_switch buffer RAM scheduler.
// FSM encoding and the fixed read latency of the output-registered RAM port B.
package gsm_sw_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int RD_LAT = 2;

endpackage

// File: rtl/sdpram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request
// found searching upward from ptr+1, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sdpram_arbiter.sv
// Scheduler for the gsm_switch simple-dual-port buffer RAM: round-robin write
// arbitration with burst lock on port A, single reader on port B.
// Handshake: a requester holds wr_req/addr/data until wr_gnt; wr_gnt and
// rd_ack are same-cycle acceptances, rd_valid follows rd_ack by RD_LAT cycles.
module sdpram_arbiter
    import gsm_sw_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 18,
    parameter int AWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          wr_req,
    input  logic [NREQ-1:0]          wr_last,
    input  logic [NREQ*AWIDTH-1:0]   wr_addr,
    input  logic [NREQ*DWIDTH-1:0]   wr_data,
    output logic [NREQ-1:0]          wr_gnt,
    input  logic                     rd_req,
    input  logic [AWIDTH-1:0]        rd_addr,
    output logic                     rd_ack,
    output logic                     rd_valid,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     ram_en_a,
    output logic                     ram_write_a,
    output logic [AWIDTH-1:0]        ram_addr_a,
    output logic [DWIDTH-1:0]        ram_wr_data_a,
    output logic                     ram_en_b,
    output logic [AWIDTH-1:0]        ram_addr_b,
    input  logic [DWIDTH-1:0]        ram_rd_data_b,
    output logic [0:0]               dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [RD_LAT-1:0] rd_pipe;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic [NREQ-1:0]   gnt_c;
    logic [IW-1:0]     gidx;
    logic              any_gnt;
    logic [AWIDTH-1:0] gaddr;
    logic [DWIDTH-1:0] gdata;
    logic              collision;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req     (wr_req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // While locked only the owner may write; its idle gaps still hold the lock.
    always_comb begin
        gnt_c = '0;
        gidx  = '0;
        if (state == ST_LOCKED) begin
            if (wr_req[owner]) begin
                gnt_c[owner] = 1'b1;
                gidx         = owner;
            end
        end else begin
            gnt_c = arb_gnt;
            gidx  = arb_idx;
        end
        if (!rst_n) begin
            gnt_c = '0;
        end
    end

    assign any_gnt = |gnt_c;
    assign gaddr   = wr_addr[gidx*AWIDTH +: AWIDTH];
    assign gdata   = wr_data[gidx*DWIDTH +: DWIDTH];

    assign wr_gnt        = gnt_c;
    assign ram_en_a      = any_gnt;
    assign ram_write_a   = any_gnt;
    assign ram_addr_a    = gaddr;
    assign ram_wr_data_a = gdata;

    // A read hitting the address being written this cycle waits one cycle so
    // it sees the new word; writes are never held back by reads.
    assign collision  = rd_req & any_gnt & (rd_addr == gaddr);
    assign rd_ack     = rd_req & ~collision & rst_n;
    assign ram_en_b   = rd_ack;
    assign ram_addr_b = rd_addr;
    assign rd_valid   = rd_pipe[RD_LAT-1];
    assign rd_data    = ram_rd_data_b;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= IW'(NREQ - 1);
            owner   <= '0;
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-2:0], rd_ack};
            if (any_gnt) begin
                if (wr_last[gidx]) begin
                    state  <= ST_IDLE;
                    rr_ptr <= gidx;
                end else if (state == ST_IDLE) begin
                    state <= ST_LOCKED;
                    owner <= gidx;
                end
            end
        end
    end

endmodule
